// File: rtl/seq_divider_if.sv
// seq_divider_if: start/operand/result bus of seq_divider; SEQ_DIVIDER_SIGNED_EN adds signed_op
interface seq_divider_if #(parameter int WIDTH = 32);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic             signed_op;
    modport master(output start, dividend, divisor, signed_op,
                   input busy, done, quotient, remainder, div_by_zero);
    modport slave(input start, dividend, divisor, signed_op,
                  output busy, done, quotient, remainder, div_by_zero);
`else
    modport master(output start, dividend, divisor,
                   input busy, done, quotient, remainder, div_by_zero);
    modport slave(input start, dividend, divisor,
                  output busy, done, quotient, remainder, div_by_zero);
`endif
endinterface

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per cycle; SEQ_DIVIDER_SIGNED_EN enables signed_op
module seq_divider #(parameter int WIDTH = 32) (
    input logic clk,
    input logic reset,
    seq_divider_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam int CW = $clog2(WIDTH);
    state_t state, next;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] q, r, d, a_mag, b_mag, res_q, res_r, fin_q, fin_r, q_hold, r_hold;
    logic [WIDTH:0] sh, trial;
    logic dz, dz_hold, accept, last;
    assign accept = state == IDLE && bus.start;
    assign last = cnt == CW'(WIDTH - 1);
    assign sh = {r, q[WIDTH-1]};
    assign trial = sh - {1'b0, d};
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_q, neg_r;
    assign a_mag = bus.signed_op && bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign b_mag = bus.signed_op && bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
    assign res_q = neg_q ? -q : q;
    assign res_r = neg_r ? -r : r;
    // capture the result signs alongside the operands
    always_ff @(posedge clk) begin
        if (reset) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= bus.signed_op & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            neg_r <= bus.signed_op & bus.dividend[WIDTH-1];
        end
    end
`else
    assign a_mag = bus.dividend;
    assign b_mag = bus.divisor;
    assign res_q = q;
    assign res_r = r;
`endif
    assign fin_q = dz ? '1 : res_q;
    assign fin_r = dz ? r : res_r;
    assign bus.busy = state == BUSY;
    assign bus.done = state == DONE;
    assign bus.quotient = state == DONE ? fin_q : q_hold;
    assign bus.remainder = state == DONE ? fin_r : r_hold;
    assign bus.div_by_zero = state == DONE ? dz : dz_hold;
    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= next;
    end
    // next state: zero divisor skips iteration entirely
    always_comb begin
        next = IDLE;
        if (state == IDLE) next = bus.start ? (bus.divisor == '0 ? DONE : BUSY) : IDLE;
        else if (state == BUSY) next = last ? DONE : BUSY;
    end
    // operand latch, shift/trial-subtract step, and result holding
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            q <= '0;
            r <= '0;
            d <= '0;
            dz <= 1'b0;
            q_hold <= '0;
            r_hold <= '0;
            dz_hold <= 1'b0;
        end else begin
            if (accept) begin
                cnt <= '0;
                q <= a_mag;
                d <= b_mag;
                dz <= bus.divisor == '0;
                r <= bus.divisor == '0 ? bus.dividend : '0;
            end else if (state == BUSY) begin
                cnt <= cnt + 1'b1;
                q <= {q[WIDTH-2:0], ~trial[WIDTH]};
                r <= trial[WIDTH] ? sh[WIDTH-1:0] : trial[WIDTH-1:0];
            end
            if (state == DONE) begin
                q_hold <= fin_q;
                r_hold <= fin_r;
                dz_hold <= dz;
            end
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random checks of seq_divider against an arithmetic model
module tb_seq_divider;
    localparam int W = 32;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int vectors = 0;
    int errs = 0;
    logic [W-1:0] prev_q = '0;
    seq_divider_if #(.WIDTH(W)) bus();
    seq_divider #(.WIDTH(W)) dut(.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] eq, output logic [W-1:0] er, output logic edz);
        logic signed [W-1:0] sa, sb;
        logic sgn;
`ifdef SEQ_DIVIDER_SIGNED_EN
        sgn = s;
`else
        sgn = 1'b0 & s;
`endif
        sa = a;
        sb = b;
        edz = b == 0;
        if (b == 0) begin
            eq = '1;
            er = a;
        end else if (!sgn) begin
            eq = a / b;
            er = a % b;
        end else if (a == {1'b1, {(W-1){1'b0}}} && sb == -1) begin
            eq = a;
            er = '0;
        end else begin
            eq = sa / sb;
            er = sa % sb;
        end
    endtask

    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int glitch_at);
        logic [W-1:0] eq, er;
        logic edz;
        int exp_k, dk, nb;
        model(a, b, s, eq, er, edz);
        exp_k = b == 0 ? 1 : W + 1;
        bus.start = 1'b1;
        bus.dividend = a;
        bus.divisor = b;
`ifdef SEQ_DIVIDER_SIGNED_EN
        bus.signed_op = s;
`endif
        dk = 0;
        nb = 0;
        for (int k = 1; k <= W + 4 && dk == 0; k++) begin
            @(negedge clk);
            if (k == 1 && exp_k > 1) check("held_q", bus.quotient, prev_q);
            if (bus.done) dk = k;
            else if (bus.busy) nb++;
            if (k == 1) begin
                bus.start = 1'b0;
                bus.dividend = $urandom;
                bus.divisor = $urandom;
            end
            if (k == glitch_at) begin
                bus.start = 1'b1;
                bus.dividend = $urandom;
                bus.divisor = $urandom;
            end
            if (k == glitch_at + 1) bus.start = 1'b0;
        end
        bus.start = 1'b0;
        check("latency", dk, exp_k);
        check("busy_cycles", nb, exp_k - 1);
        check("quotient", bus.quotient, eq);
        check("remainder", bus.remainder, er);
        check("div_by_zero", bus.div_by_zero, edz);
        prev_q = eq;
        @(negedge clk);
        check("done_pulse", bus.done, 1'b0);
        check("hold_q", bus.quotient, eq);
        check("hold_r", bus.remainder, er);
    endtask

    initial begin
        int dn;
        logic [W-1:0] a, b;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
        bus.signed_op = 1'b0;
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_q", bus.quotient, 0);
        check("rst_r", bus.remainder, 0);
        check("rst_dz", bus.div_by_zero, 1'b0);
        bus.start = 1'b1;
        bus.dividend = 100;
        bus.divisor = 7;
        @(negedge clk);
        bus.start = 1'b0;
        check("mid_busy", bus.busy, 1'b1);
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_q", bus.quotient, 0);
        check("abort_r", bus.remainder, 0);
        check("abort_dz", bus.div_by_zero, 1'b0);
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) dn++;
        end
        check("abort_idle", dn, 0);
        do_div(100, 7, 1'b0, 0);
        do_div(32'hFFFF_FFFF, 1, 1'b0, 0);
        do_div(5, 9, 1'b0, 0);
        do_div(0, 3, 1'b0, 0);
        do_div(1234, 0, 1'b0, 0);
        do_div(1000, 33, 1'b0, 5);
        do_div(77, 5, 1'b0, 0);
`ifdef SEQ_DIVIDER_SIGNED_EN
        do_div(-7, 2, 1'b1, 0);
        do_div(7, -2, 1'b1, 0);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        do_div(-1234, 0, 1'b1, 0);
`endif
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = i % 4 == 0 ? W'($urandom_range(1, 15)) : i % 4 == 1 ? W'($urandom) :
                i % 4 == 2 ? a >> $urandom_range(0, 31) : W'($urandom_range(0, 3));
            do_div(a, b, 1'($urandom_range(0, 1)), i % 5 == 0 ? 4 : 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
